// File: rtl/uart_io_pkg.sv
// Shared constants for the UART register controller: command opcodes,
// reply bytes and the controller state encoding.
package uart_io_pkg;

  localparam logic [7:0] OP_LED  = 8'h4C;  // 'L'
  localparam logic [7:0] OP_VSW  = 8'h57;  // 'W'
  localparam logic [7:0] OP_MODE = 8'h4D;  // 'M'
  localparam logic [7:0] OP_STAT = 8'h53;  // 'S'

  localparam logic [7:0] RPL_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RPL_ERR = 8'h3F;  // '?'
  localparam logic [7:0] RPL_TMO = 8'h54;  // 'T'

  typedef enum logic [2:0] {
    IDLE,
    ARG,
    EXEC,
    TX_REQ,
    TX_WAIT
  } state_t;

  function automatic logic needs_arg(input logic [7:0] op);
    return (op == OP_LED) || (op == OP_VSW) || (op == OP_MODE);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for quasi-static asynchronous inputs; each bit is
// synchronized independently, so multi-bit values may settle over two samples.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_io_ctrl.sv
// Byte-command register controller between UART RX/TX and the core: LED
// register, virtual switches, switch source select and status readback.
module uart_io_ctrl
  import uart_io_pkg::*;
#(
  parameter int CLK_HZ         = 25000000,
  parameter int TIMEOUT_CYCLES = CLK_HZ / 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic [5:0] switch_n,
  output logic [5:0] led_out,
  output logic [5:0] switch_eff,
  output logic       overrun,
  output state_t     fsm_state
);

  // Handshakes: rx_valid is a one-cycle strobe with no backpressure, so a
  // byte arriving while a command is in flight is dropped and flagged in
  // overrun. tx_start is a one-cycle request issued only while tx_busy=0;
  // tx_data is held from the request until the controller is idle again.

  localparam int            CW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  state_t        state;
  logic [7:0]    opcode;
  logic [5:0]    arg;
  logic [CW-1:0] cnt;
  logic          wait_first;
  logic [5:0]    virt_sw;
  logic          mode_virt;
  logic [5:0]    sw_sync;
  logic [5:0]    sw_phys;

  sync_2ff #(
    .WIDTH    (6),
    .RESET_VAL(6'h3F)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (switch_n),
    .q  (sw_sync)
  );

  assign sw_phys    = ~sw_sync;
  assign switch_eff = mode_virt ? virt_sw : sw_phys;
  assign fsm_state  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      opcode     <= '0;
      arg        <= '0;
      cnt        <= '0;
      wait_first <= 1'b0;
      led_out    <= '0;
      virt_sw    <= '0;
      mode_virt  <= 1'b0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            opcode <= rx_data;
            if (needs_arg(rx_data)) begin
              cnt   <= '0;
              state <= ARG;
            end else if (rx_data == OP_STAT) begin
              state <= EXEC;
            end else begin
              tx_data <= RPL_ERR;
              state   <= TX_REQ;
            end
          end
        end
        ARG: begin
          if (rx_valid) begin
            arg   <= rx_data[5:0];
            state <= EXEC;
          end else if (cnt == CNT_LAST) begin
            tx_data <= RPL_TMO;
            state   <= TX_REQ;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        EXEC: begin
          case (opcode)
            OP_LED: begin
              led_out <= arg;
              tx_data <= RPL_OK;
            end
            OP_VSW: begin
              virt_sw <= arg;
              tx_data <= RPL_OK;
            end
            OP_MODE: begin
              mode_virt <= arg[0];
              tx_data   <= RPL_OK;
            end
            OP_STAT: tx_data <= {2'b00, switch_eff};
            default: tx_data <= RPL_ERR;
          endcase
          state <= TX_REQ;
        end
        TX_REQ: begin
          if (!tx_busy) begin
            tx_start   <= 1'b1;
            wait_first <= 1'b1;
            state      <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          // The transmitter raises tx_busy a cycle after tx_start, so the
          // first TX_WAIT cycle must not treat tx_busy=0 as completion.
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (!tx_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (rx_valid && (state == EXEC || state == TX_REQ || state == TX_WAIT)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Directed bench for uart_io_ctrl with a 50-cycle argument timeout.
module tb_uart_io_ctrl;
  import uart_io_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [5:0] switch_n;
  logic [5:0] led_out;
  logic [5:0] switch_eff;
  logic       overrun;
  state_t     fsm_state;

  int checks = 0;
  int fails  = 0;

  uart_io_ctrl #(
    .CLK_HZ        (5000),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .switch_n  (switch_n),
    .led_out   (led_out),
    .switch_eff(switch_eff),
    .overrun   (overrun),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Latency is counted in negedges after send_byte returns; lat=-1 means no pulse.
  task automatic wait_reply(input int budget, output int lat, output int pulses,
                            output logic [7:0] data);
    lat    = -1;
    pulses = 0;
    data   = 8'h00;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_start) begin
        if (lat < 0) lat = i + 1;
        pulses++;
        data = tx_data;
      end
      if (lat >= 0 && fsm_state == IDLE) break;
    end
  endtask

  task automatic test_reset;
    switch_n = 6'h3F;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_busy  = 1'b0;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (led_out !== 6'h00) begin fails++; $display("FAIL reset_led got=%h exp=00", led_out); end
    checks++; if (tx_start !== 1'b0) begin fails++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (switch_eff !== 6'h00) begin fails++; $display("FAIL reset_switch_eff got=%h exp=00", switch_eff); end
    checks++; if (fsm_state !== IDLE) begin fails++; $display("FAIL reset_state got=%0d exp=%0d", fsm_state, IDLE); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_led;
    int lat, pulses;
    logic [7:0] d;
    send_byte(OP_LED);
    send_byte(8'h2A);
    wait_reply(20, lat, pulses, d);
    checks++; if (pulses !== 1) begin fails++; $display("FAIL led_pulses got=%0d exp=1", pulses); end
    checks++; if (d !== 8'h4B) begin fails++; $display("FAIL led_reply got=%h exp=4b", d); end
    checks++; if (led_out !== 6'h2A) begin fails++; $display("FAIL led_value got=%h exp=2a", led_out); end
  endtask

  task automatic test_status;
    int lat, pulses;
    logic [7:0] d;
    switch_n = 6'b110101;
    repeat (4) @(negedge clk);
    checks++; if (switch_eff !== 6'h0A) begin fails++; $display("FAIL sw_phys got=%h exp=0a", switch_eff); end
    send_byte(OP_STAT);
    wait_reply(20, lat, pulses, d);
    checks++; if (d !== 8'h0A) begin fails++; $display("FAIL stat_phys_reply got=%h exp=0a", d); end
    checks++; if (lat !== 2) begin fails++; $display("FAIL stat_latency got=%0d exp=2", lat); end
    send_byte(OP_MODE);
    send_byte(8'h01);
    wait_reply(20, lat, pulses, d);
    checks++; if (d !== 8'h4B) begin fails++; $display("FAIL mode_reply got=%h exp=4b", d); end
    checks++; if (switch_eff !== 6'h00) begin fails++; $display("FAIL mode_eff got=%h exp=00", switch_eff); end
    send_byte(OP_VSW);
    send_byte(8'h3F);
    wait_reply(20, lat, pulses, d);
    checks++; if (d !== 8'h4B) begin fails++; $display("FAIL vsw_reply got=%h exp=4b", d); end
    send_byte(OP_STAT);
    wait_reply(20, lat, pulses, d);
    checks++; if (d !== 8'h3F) begin fails++; $display("FAIL stat_virt_reply got=%h exp=3f", d); end
    checks++; if (switch_eff !== 6'h3F) begin fails++; $display("FAIL virt_eff got=%h exp=3f", switch_eff); end
  endtask

  task automatic test_timeout;
    int lat, pulses;
    logic [7:0] d;
    send_byte(OP_LED);
    wait_reply(80, lat, pulses, d);
    checks++; if (d !== RPL_TMO) begin fails++; $display("FAIL tmo_reply got=%h exp=54", d); end
    checks++; if (lat !== 51) begin fails++; $display("FAIL tmo_latency got=%0d exp=51", lat); end
    checks++; if (pulses !== 1) begin fails++; $display("FAIL tmo_pulses got=%0d exp=1", pulses); end
    checks++; if (led_out !== 6'h2A) begin fails++; $display("FAIL tmo_led got=%h exp=2a", led_out); end
    checks++; if (fsm_state !== IDLE) begin fails++; $display("FAIL tmo_state got=%0d exp=%0d", fsm_state, IDLE); end
  endtask

  task automatic test_unknown_busy;
    int lat, pulses;
    int early;
    logic [7:0] d;
    tx_busy = 1'b1;
    send_byte(8'h5A);
    early = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_start) early++;
    end
    checks++; if (early !== 0) begin fails++; $display("FAIL busy_withheld got=%0d exp=0", early); end
    checks++; if (tx_data !== RPL_ERR) begin fails++; $display("FAIL busy_tx_data got=%h exp=3f", tx_data); end
    checks++; if (fsm_state !== TX_REQ) begin fails++; $display("FAIL busy_state got=%0d exp=%0d", fsm_state, TX_REQ); end
    tx_busy = 1'b0;
    wait_reply(20, lat, pulses, d);
    checks++; if (pulses !== 1) begin fails++; $display("FAIL unk_pulses got=%0d exp=1", pulses); end
    checks++; if (d !== RPL_ERR) begin fails++; $display("FAIL unk_reply got=%h exp=3f", d); end
    checks++; if (lat !== 1) begin fails++; $display("FAIL unk_latency got=%0d exp=1", lat); end
  endtask

  task automatic test_overrun;
    int lat, pulses, seen;
    logic [7:0] d;
    send_byte(OP_STAT);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_start) begin seen = 1; break; end
    end
    checks++; if (seen !== 1) begin fails++; $display("FAIL ovr_start got=%0d exp=1", seen); end
    tx_busy = 1'b1;
    send_byte(OP_LED);
    checks++; if (fsm_state !== TX_WAIT) begin fails++; $display("FAIL ovr_state got=%0d exp=%0d", fsm_state, TX_WAIT); end
    checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag got=%b exp=1", overrun); end
    tx_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fsm_state == IDLE) break;
    end
    checks++; if (fsm_state !== IDLE) begin fails++; $display("FAIL ovr_idle got=%0d exp=%0d", fsm_state, IDLE); end
    send_byte(OP_LED);
    send_byte(8'h15);
    wait_reply(20, lat, pulses, d);
    checks++; if (d !== RPL_OK) begin fails++; $display("FAIL ovr_next_reply got=%h exp=4b", d); end
    checks++; if (led_out !== 6'h15) begin fails++; $display("FAIL ovr_next_led got=%h exp=15", led_out); end
    checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_reset_mid;
    int lat, pulses, spurious;
    logic [7:0] d;
    send_byte(OP_VSW);
    checks++; if (fsm_state !== ARG) begin fails++; $display("FAIL mid_arg_state got=%0d exp=%0d", fsm_state, ARG); end
    spurious = 0;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (tx_start) spurious++;
    end
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL mid_overrun got=%b exp=0", overrun); end
    checks++; if (led_out !== 6'h00) begin fails++; $display("FAIL mid_led got=%h exp=00", led_out); end
    rst = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (tx_start) spurious++;
    end
    checks++; if (spurious !== 0) begin fails++; $display("FAIL mid_no_start got=%0d exp=0", spurious); end
    checks++; if (switch_eff !== 6'h0A) begin fails++; $display("FAIL mid_eff got=%h exp=0a", switch_eff); end
    send_byte(OP_MODE);
    send_byte(8'h01);
    wait_reply(20, lat, pulses, d);
    send_byte(OP_STAT);
    wait_reply(20, lat, pulses, d);
    checks++; if (d !== 8'h00) begin fails++; $display("FAIL mid_virt_sw got=%h exp=00", d); end
  endtask

  initial begin
    test_reset();
    test_led();
    test_status();
    test_timeout();
    test_unknown_busy();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
